// File: rtl/picorv_mem_arbiter.sv
// rtl/picorv_mem_arbiter.sv - round-robin arbiter sharing one picorv memory port between two masters
// Owner is latched in IDLE; the port is driven combinationally from the owner while BUSY.
module picorv_mem_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic        w_busy;
    logic        w_own_valid;
    logic        w_tmo;
    logic        w_done;
    logic        w_leave;
    logic        w_pick;
    logic [31:0] w_resp;

    always_comb begin
        w_busy      = (r_state == BUSY);
        w_own_valid = r_owner ? m1_valid : m0_valid;
        // s_ready on the last allowed wait cycle wins over the forced completion
        w_tmo       = w_busy && w_own_valid && !s_ready && (r_cnt == 8'(TIMEOUT - 1));
        w_done      = w_busy && w_own_valid && (s_ready || w_tmo);
        w_leave     = w_busy && (!w_own_valid || s_ready || w_tmo);
        w_pick      = (m0_valid && m1_valid) ? ~r_last : m1_valid;
        w_resp      = s_ready ? s_rdata : ERR_DATA;
    end

    always_comb begin
        w_next      = r_state;
        s_valid     = 1'b0;
        grant       = 2'b00;
        s_addr      = 32'h0;
        s_wdata     = 32'h0;
        s_wstrb     = 4'h0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = 32'h0;
        m1_rdata    = 32'h0;
        timeout_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_valid || m1_valid) w_next = BUSY;
            end
            BUSY: begin
                s_valid     = 1'b1;
                grant       = r_owner ? 2'b10 : 2'b01;
                s_addr      = r_owner ? m1_addr  : m0_addr;
                s_wdata     = r_owner ? m1_wdata : m0_wdata;
                s_wstrb     = r_owner ? m1_wstrb : m0_wstrb;
                m0_ready    = w_done && !r_owner;
                m1_ready    = w_done && r_owner;
                m0_rdata    = (w_done && !r_owner) ? w_resp : 32'h0;
                m1_rdata    = (w_done && r_owner)  ? w_resp : 32'h0;
                timeout_err = w_tmo;
                if (w_leave) w_next = RELEASE;
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'h0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (m0_valid || m1_valid)) begin
                r_owner <= w_pick;
                r_cnt   <= 8'h0;
            end
            if (w_busy) begin
                if (w_leave) r_last <= r_owner;
                else         r_cnt  <= r_cnt + 8'h1;
            end
        end
    end

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// tb/tb_picorv_mem_arbiter.sv - directed and randomized self-checking bench for picorv_mem_arbiter
module tb_picorv_mem_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    picorv_mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step_clk();
        step_clk();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        reset = 1;
        step_clk();
        step_clk();
        at_neg();
        total++; if ({s_valid, grant, m0_ready, m1_ready, timeout_err} !== 6'b0) $display("FAIL reset_outputs got %b want 000000", {s_valid, grant, m0_ready, m1_ready, timeout_err}); else passed++;
        reset = 0;
        step_clk();
        at_neg();
        total++; if (grant !== 2'b01) $display("FAIL reset_first_contest got %b want 01", grant); else passed++;
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0; s_rdata = 32'h12345678;
        at_neg();
        total++; if (s_valid !== 1'b0) $display("FAIL read_req_cycle_svalid got %b want 0", s_valid); else passed++;
        step_clk();
        at_neg();
        total++; if ({s_valid, grant, s_addr} !== {1'b1, 2'b01, 32'h10}) $display("FAIL read_issue got %h want %h", {s_valid, grant, s_addr}, {1'b1, 2'b01, 32'h10}); else passed++;
        total++; if (m0_ready !== 1'b0) $display("FAIL read_early_ready got %b want 0", m0_ready); else passed++;
        step_clk();
        at_neg();
        total++; if (m0_ready !== 1'b0) $display("FAIL read_wait2_ready got %b want 0", m0_ready); else passed++;
        step_clk();
        s_ready = 1;
        at_neg();
        total++; if ({m0_ready, m0_rdata, m1_ready, timeout_err} !== {1'b1, 32'h12345678, 1'b0, 1'b0}) $display("FAIL read_done got %h want %h", {m0_ready, m0_rdata, m1_ready, timeout_err}, {1'b1, 32'h12345678, 1'b0, 1'b0}); else passed++;
        step_clk();
        m0_valid = 0; s_ready = 0;
        at_neg();
        total++; if ({s_valid, grant, m0_ready, m1_ready} !== 5'b0) $display("FAIL read_release got %b want 00000", {s_valid, grant, m0_ready, m1_ready}); else passed++;
        step_clk();
        at_neg();
        total++; if ({s_valid, grant} !== 3'b0) $display("FAIL read_idle got %b want 000", {s_valid, grant}); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        for (int i = 0; i < 12; i++) begin
            at_neg();
            exp_g = (i % 3 != 1) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
            total++; if ({grant, m1_ready, m0_ready} !== {exp_g, exp_g}) $display("FAIL rr_cycle%0d got %b want %b", i, {grant, m1_ready, m0_ready}, {exp_g, exp_g}); else passed++;
            step_clk();
        end
        idle_inputs();
    endtask

    task automatic test_write_mux();
        do_reset();
        m1_valid = 1; m1_addr = 32'h100; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'b0011;
        step_clk();
        for (int k = 0; k < 3; k++) begin
            m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            at_neg();
            total++; if ({grant, s_addr, s_wdata, s_wstrb} !== {2'b10, 32'h100, 32'hCAFEF00D, 4'b0011}) $display("FAIL write_mux%0d got %h want %h", k, {grant, s_addr, s_wdata, s_wstrb}, {2'b10, 32'h100, 32'hCAFEF00D, 4'b0011}); else passed++;
            step_clk();
        end
        s_ready = 1; s_rdata = 32'h55AA33CC;
        at_neg();
        total++; if ({m1_ready, m1_rdata, m0_ready, m0_rdata, timeout_err} !== {1'b1, 32'h55AA33CC, 1'b0, 32'h0, 1'b0}) $display("FAIL write_done_on_limit got %h want %h", {m1_ready, m1_rdata, m0_ready, m0_rdata, timeout_err}, {1'b1, 32'h55AA33CC, 1'b0, 32'h0, 1'b0}); else passed++;
        step_clk();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_valid = 1; s_rdata = 32'h0BADF00D;
        step_clk();
        for (int w = 1; w <= TMO; w++) begin
            at_neg();
            if (w < TMO) begin
                total++; if ({m0_ready, timeout_err} !== 2'b00) $display("FAIL tmo_wait%0d got %b want 00", w, {m0_ready, timeout_err}); else passed++;
            end else begin
                total++; if ({m0_ready, timeout_err, m0_rdata} !== {2'b11, ERR}) $display("FAIL tmo_forced got %h want %h", {m0_ready, timeout_err, m0_rdata}, {2'b11, ERR}); else passed++;
            end
            step_clk();
        end
        m0_valid = 0;
        at_neg();
        total++; if ({s_valid, timeout_err} !== 2'b00) $display("FAIL tmo_release got %b want 00", {s_valid, timeout_err}); else passed++;
        step_clk();
        m0_valid = 1;
        step_clk();
        for (int w = 1; w <= TMO; w++) begin
            if (w == TMO) s_ready = 1;
            at_neg();
            if (w < TMO) begin
                total++; if (m0_ready !== 1'b0) $display("FAIL tmo2_wait%0d got %b want 0", w, m0_ready); else passed++;
            end else begin
                total++; if ({m0_ready, timeout_err, m0_rdata} !== {2'b10, 32'h0BADF00D}) $display("FAIL tmo_ready_priority got %h want %h", {m0_ready, timeout_err, m0_rdata}, {2'b10, 32'h0BADF00D}); else passed++;
            end
            step_clk();
        end
        idle_inputs();
    endtask

    task automatic test_reset_busy();
        do_reset();
        m0_valid = 1;
        step_clk();
        at_neg();
        total++; if (s_valid !== 1'b1) $display("FAIL rb_busy got %b want 1", s_valid); else passed++;
        reset = 1;
        step_clk();
        at_neg();
        total++; if ({s_valid, grant, m0_ready, m1_ready} !== 5'b0) $display("FAIL rb_dropped got %b want 00000", {s_valid, grant, m0_ready, m1_ready}); else passed++;
        reset = 0; m1_valid = 1;
        step_clk();
        at_neg();
        total++; if (grant !== 2'b01) $display("FAIL rb_contest got %b want 01", grant); else passed++;
        idle_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        m0_valid = 1;
        step_clk();
        m1_valid = 1;
        at_neg();
        total++; if (grant !== 2'b01) $display("FAIL abort_owner got %b want 01", grant); else passed++;
        step_clk();
        m0_valid = 0; s_ready = 1;
        at_neg();
        total++; if ({m0_ready, m1_ready, timeout_err} !== 3'b0) $display("FAIL abort_no_ready got %b want 000", {m0_ready, m1_ready, timeout_err}); else passed++;
        step_clk();
        s_ready = 0;
        at_neg();
        total++; if ({s_valid, grant} !== 3'b0) $display("FAIL abort_release got %b want 000", {s_valid, grant}); else passed++;
        step_clk();
        at_neg();
        total++; if ({s_valid, grant} !== 3'b0) $display("FAIL abort_idle got %b want 000", {s_valid, grant}); else passed++;
        step_clk();
        at_neg();
        total++; if (grant !== 2'b10) $display("FAIL abort_pending_m1 got %b want 10", grant); else passed++;
        idle_inputs();
    endtask

    // Transaction-level reference: who owns the port, how long it has waited, who went last.
    task automatic test_random();
        int          owner = -1;
        int          waits = 0;
        int          last  = 1;
        bit          gap   = 0;
        bit          got0  = 0;
        bit          got1  = 0;
        bit          ov, fin, tmo;
        logic [137:0] exp_v, act_v;
        logic [31:0]  e_rd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m0_valid = (got0 || !m0_valid) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 97);
            m1_valid = (got1 || !m1_valid) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 97);
            m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            s_ready = ($urandom_range(0, 99) < 35); s_rdata = $urandom;
            at_neg();
            exp_v = '0; got0 = 0; got1 = 0; fin = 0;
            if (owner >= 0) begin
                ov   = (owner == 1) ? m1_valid : m0_valid;
                tmo  = ov && !s_ready && (waits + 1 == TMO);
                fin  = !ov || s_ready || tmo;
                e_rd = s_ready ? s_rdata : ERR;
                got0 = ov && (s_ready || tmo) && (owner == 0);
                got1 = ov && (s_ready || tmo) && (owner == 1);
                exp_v = {1'b1, (owner == 1) ? 2'b10 : 2'b01,
                         (owner == 1) ? m1_addr : m0_addr,
                         (owner == 1) ? m1_wdata : m0_wdata,
                         (owner == 1) ? m1_wstrb : m0_wstrb,
                         got0, got0 ? e_rd : 32'h0, got1, got1 ? e_rd : 32'h0, tmo};
            end
            act_v = {s_valid, grant, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err};
            total++; if (act_v !== exp_v) $display("FAIL random_cycle%0d got %h want %h", c, act_v, exp_v); else passed++;
            if (owner >= 0) begin
                if (fin) begin last = owner; owner = -1; gap = 1; end
                else waits++;
            end else if (gap) begin
                gap = 0;
            end else if (m0_valid || m1_valid) begin
                owner = (m0_valid && m1_valid) ? 1 - last : (m1_valid ? 1 : 0);
                waits = 0;
            end
            step_clk();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step_clk();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_mux();
        test_timeout();
        test_reset_busy();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
